// File: rtl/pattern_response_compactor_if.sv
// Bus between the pattern circuit driver and the response compactor.
// Handshake: resp_valid qualifies resp_in on the rising clock edge; there is
// no ready, the compactor accepts every valid response while capturing and
// ignores resp_valid in all other states.
interface pattern_response_compactor_if #(
  parameter int RESP_W = 9,
  parameter int SIG_W  = 16,
  parameter int CNT_W  = 8
);
  logic [RESP_W-1:0] resp_in;
  logic              resp_valid;
  logic              start;
  logic              abort;
  logic [CNT_W-1:0]  num_patterns;
  logic [SIG_W-1:0]  golden;
  logic [SIG_W-1:0]  signature;
  logic [CNT_W-1:0]  pat_cnt;
  logic              busy;
  logic              done;
  logic              pass;

  // Driver side: supplies responses and run control, observes results.
  modport master (
    output resp_in, resp_valid, start, abort, num_patterns, golden,
    input  signature, pat_cnt, busy, done, pass
  );

  // Compactor side.
  modport slave (
    input  resp_in, resp_valid, start, abort, num_patterns, golden,
    output signature, pat_cnt, busy, done, pass
  );
endinterface

// File: rtl/pattern_response_compactor.sv
// MISR-based response compactor: folds N upstream response words into a
// signature, then compares it against a golden value latched at start.
module pattern_response_compactor #(
  parameter int RESP_W = 9,
  parameter int SIG_W  = 16,
  parameter int CNT_W  = 8
) (
  input  logic                            blif_clk_net,
  input  logic                            blif_reset_net,
  pattern_response_compactor_if.slave     bus,
  output logic [1:0]                      state_o
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_CAPTURE = 2'd1,
    S_COMPARE = 2'd2,
    S_DONE    = 2'd3
  } state_t;

  localparam logic [SIG_W-1:0] POLY     = SIG_W'(16'h1021);
  localparam logic [SIG_W-1:0] SIG_SEED = {SIG_W{1'b1}};

  state_t            state_q, state_d;
  logic [SIG_W-1:0]  sig_q, sig_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [CNT_W-1:0]  n_q, n_d;
  logic [SIG_W-1:0]  golden_q, golden_d;
  logic              pass_q, pass_d;

  logic start_ok;
  logic accept;
  logic last_resp;

  // A start is honoured only between runs and loses to a simultaneous abort.
  assign start_ok  = bus.start && !bus.abort &&
                     (state_q == S_IDLE || state_q == S_DONE);
  assign accept    = (state_q == S_CAPTURE) && bus.resp_valid && !bus.abort;
  assign last_resp = accept && (cnt_q == n_q - CNT_W'(1));

  // State register.
  always_ff @(posedge blif_clk_net) begin
    if (!blif_reset_net) state_q <= S_IDLE;
    else                 state_q <= state_d;
  end

  // Next-state logic; abort wins over everything except in IDLE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (start_ok) state_d = (bus.num_patterns == '0) ? S_COMPARE : S_CAPTURE;
      end
      S_CAPTURE: begin
        if (bus.abort)     state_d = S_IDLE;
        else if (last_resp) state_d = S_COMPARE;
      end
      S_COMPARE: begin
        if (bus.abort) state_d = S_IDLE;
        else           state_d = S_DONE;
      end
      S_DONE: begin
        if (bus.abort)     state_d = S_IDLE;
        else if (start_ok) state_d = (bus.num_patterns == '0) ? S_COMPARE : S_CAPTURE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Status outputs decoded from registered state only.
  always_comb begin
    bus.busy = (state_q == S_CAPTURE) || (state_q == S_COMPARE);
    bus.done = (state_q == S_DONE);
    state_o  = state_q;
  end

  // Datapath next values: run setup, MISR step, compare result, abort clear.
  always_comb begin
    sig_d    = sig_q;
    cnt_d    = cnt_q;
    n_d      = n_q;
    golden_d = golden_q;
    pass_d   = pass_q;
    if (start_ok) begin
      sig_d    = SIG_SEED;
      cnt_d    = '0;
      n_d      = bus.num_patterns;
      golden_d = bus.golden;
      pass_d   = 1'b0;
    end else if (bus.abort && state_q != S_IDLE) begin
      pass_d = 1'b0;
    end else if (accept) begin
      sig_d = {sig_q[SIG_W-2:0], 1'b0} ^ (sig_q[SIG_W-1] ? POLY : '0) ^
              SIG_W'(bus.resp_in);
      cnt_d = cnt_q + CNT_W'(1);
    end else if (state_q == S_COMPARE) begin
      pass_d = (sig_q == golden_q);
    end
  end

  // Datapath registers.
  always_ff @(posedge blif_clk_net) begin
    if (!blif_reset_net) begin
      sig_q    <= SIG_SEED;
      cnt_q    <= '0;
      n_q      <= '0;
      golden_q <= '0;
      pass_q   <= 1'b0;
    end else begin
      sig_q    <= sig_d;
      cnt_q    <= cnt_d;
      n_q      <= n_d;
      golden_q <= golden_d;
      pass_q   <= pass_d;
    end
  end

  assign bus.signature = sig_q;
  assign bus.pat_cnt   = cnt_q;
  assign bus.pass      = pass_q;

endmodule

// File: tb/tb_pattern_response_compactor.sv
// Directed bench for the response compactor with hand-computed signatures.
module tb_pattern_response_compactor;
  localparam int RESP_W = 9;
  localparam int SIG_W  = 16;
  localparam int CNT_W  = 8;

  logic       clk;
  logic       rst_n;
  logic [1:0] state_o;
  int         checks;
  int         failures;
  int         done_seen;
  int         lat;

  pattern_response_compactor_if #(.RESP_W(RESP_W), .SIG_W(SIG_W), .CNT_W(CNT_W)) bus ();

  pattern_response_compactor #(.RESP_W(RESP_W), .SIG_W(SIG_W), .CNT_W(CNT_W)) dut (
    .blif_clk_net  (clk),
    .blif_reset_net(rst_n),
    .bus           (bus.slave),
    .state_o       (state_o)
  );

  // Clock and reset.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick(2);
    rst_n = 1'b1;
  endtask

  task automatic start_run(input logic [CNT_W-1:0] n, input logic [SIG_W-1:0] g);
    bus.start        = 1'b1;
    bus.num_patterns = n;
    bus.golden       = g;
    tick(1);
    bus.start = 1'b0;
  endtask

  task automatic send_resp(input logic [RESP_W-1:0] r);
    bus.resp_in    = r;
    bus.resp_valid = 1'b1;
    tick(1);
    bus.resp_valid = 1'b0;
    bus.resp_in    = '0;
  endtask

  // Bounded wait for done; returns edges taken, or -1 on timeout.
  task automatic wait_done(output int edges);
    edges = -1;
    for (int i = 1; i <= 20; i++) begin
      tick(1);
      if (bus.done) begin
        edges = i;
        break;
      end
    end
  endtask

  initial begin
    checks = 0; failures = 0;
    bus.resp_in = '0; bus.resp_valid = 1'b0; bus.start = 1'b0; bus.abort = 1'b0;
    bus.num_patterns = '0; bus.golden = '0;
    rst_n = 1'b1;
    do_reset();

    // Reset state.
    check_val("rst_state", 32'(state_o), 32'd0);
    check_val("rst_sig",   32'(bus.signature), 32'hFFFF);
    check_val("rst_cnt",   32'(bus.pat_cnt), 32'd0);
    check_val("rst_busy",  32'(bus.busy), 32'd0);
    check_val("rst_done",  32'(bus.done), 32'd0);
    check_val("rst_pass",  32'(bus.pass), 32'd0);

    // Single pattern, matching golden.
    start_run(8'd1, 16'hEE20);
    check_val("p1_busy", 32'(bus.busy), 32'd1);
    send_resp(9'h1FF);
    check_val("p1_sig",  32'(bus.signature), 32'hEE20);
    check_val("p1_cnt",  32'(bus.pat_cnt), 32'd1);
    check_val("p1_done_early", 32'(bus.done), 32'd0);
    wait_done(lat);
    check_val("p1_lat",  32'(lat), 32'd1);
    check_val("p1_pass", 32'(bus.pass), 32'd1);
    // DONE holds and ignores resp_valid.
    send_resp(9'h0AA);
    tick(2);
    check_val("p1_hold_sig",  32'(bus.signature), 32'hEE20);
    check_val("p1_hold_done", 32'(bus.done), 32'd1);
    check_val("p1_hold_pass", 32'(bus.pass), 32'd1);

    // Same response, mismatching golden; start straight from DONE.
    start_run(8'd1, 16'hEFDF);
    check_val("mm_pass_clr", 32'(bus.pass), 32'd0);
    send_resp(9'h1FF);
    wait_done(lat);
    check_val("mm_lat",  32'(lat), 32'd1);
    check_val("mm_sig",  32'(bus.signature), 32'hEE20);
    check_val("mm_pass", 32'(bus.pass), 32'd0);

    // Zero-pattern run goes straight to COMPARE.
    start_run(8'd0, 16'hFFFF);
    check_val("z_state", 32'(state_o), 32'd2);
    check_val("z_busy",  32'(bus.busy), 32'd1);
    tick(1);
    check_val("z_done",  32'(bus.done), 32'd1);
    check_val("z_pass",  32'(bus.pass), 32'd1);
    check_val("z_cnt",   32'(bus.pat_cnt), 32'd0);

    // Gapped valid, two zero responses.
    start_run(8'd2, 16'hCF9F);
    send_resp(9'h000);
    check_val("g_sig1", 32'(bus.signature), 32'hEFDF);
    check_val("g_cnt1", 32'(bus.pat_cnt), 32'd1);
    bus.start = 1'b1;          // ignored while capturing
    tick(3);
    bus.start = 1'b0;
    check_val("g_gap_sig",  32'(bus.signature), 32'hEFDF);
    check_val("g_gap_cnt",  32'(bus.pat_cnt), 32'd1);
    check_val("g_gap_done", 32'(bus.done), 32'd0);
    check_val("g_gap_busy", 32'(bus.busy), 32'd1);
    send_resp(9'h000);
    check_val("g_sig2", 32'(bus.signature), 32'hCF9F);
    check_val("g_cnt2", 32'(bus.pat_cnt), 32'd2);
    wait_done(lat);
    check_val("g_lat",  32'(lat), 32'd1);
    check_val("g_pass", 32'(bus.pass), 32'd1);

    // Abort and start together mid-capture.
    start_run(8'd4, 16'h1234);
    send_resp(9'h055);
    bus.abort = 1'b1; bus.start = 1'b1;
    tick(1);
    bus.abort = 1'b0; bus.start = 1'b0;
    check_val("ab_state", 32'(state_o), 32'd0);
    check_val("ab_busy",  32'(bus.busy), 32'd0);
    check_val("ab_done",  32'(bus.done), 32'd0);
    check_val("ab_cnt",   32'(bus.pat_cnt), 32'd1);
    check_val("ab_sig",   32'(bus.signature), 32'hEF8A);

    // Reset mid-capture discards the run.
    start_run(8'd4, 16'h1234);
    send_resp(9'h1FF);
    rst_n = 1'b0;
    tick(1);
    rst_n = 1'b1;
    check_val("rr_state", 32'(state_o), 32'd0);
    check_val("rr_sig",   32'(bus.signature), 32'hFFFF);
    check_val("rr_cnt",   32'(bus.pat_cnt), 32'd0);
    done_seen = 0;
    for (int i = 0; i < 10; i++) begin
      tick(1);
      if (bus.done || bus.busy) done_seen++;
    end
    check_val("rr_no_done", 32'(done_seen), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
